// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and default widths for the UART transmit path
package uart_pkg;

  localparam int UART_DBIT       = 8;
  localparam int UART_TXQ_ADDR_W = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - host write port, queue status and transmitter handshake of uart_tx_feeder
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DBIT   = UART_DBIT,
  parameter int ADDR_W = UART_TXQ_ADDR_W
);

  logic              wr;
  logic [DBIT-1:0]   w_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              tx_start;
  logic [DBIT-1:0]   tx_din;
  logic              tx_done_tick;
  logic              busy;
  logic              ovf;
  logic              ovf_clr;

  modport master (
    output wr, w_data, tx_done_tick, ovf_clr,
    input  full, empty, level, tx_start, tx_din, busy, ovf
  );

  modport slave (
    input  wr, w_data, tx_done_tick, ovf_clr,
    output full, empty, level, tx_start, tx_din, busy, ovf
  );

endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - 2^ADDR_W-deep word FIFO with wrap-bit pointers, level and full/empty flags
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DBIT   = UART_DBIT,
  parameter int ADDR_W = UART_TXQ_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd,
  output logic [DBIT-1:0]   r_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DBIT-1:0] mem_q [DEPTH];
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            push;
  logic            pop;

  // Flags come from the registered pointers, so a write that coincides with a pop while full is still dropped.
  always_comb begin
    full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
               (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    level    = wr_ptr_q - rd_ptr_q;
    push     = wr && !full;
    pop      = rd && !empty;
    wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(push);
    rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(pop);
  end

  assign r_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= w_data;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - queues host bytes and feeds them one frame at a time to the UART transmitter
// Optional sticky overflow flag enabled by defining UART_TXQ_OVF_EN.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DBIT   = UART_DBIT,
  parameter int ADDR_W = UART_TXQ_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_feeder_if.slave  bus
);

  tx_state_e state_q, state_d;
  logic      tx_start;
  logic      busy;

  uart_fifo #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (bus.wr),
    .w_data (bus.w_data),
    .rd     (tx_start),
    .r_data (bus.tx_din),
    .full   (bus.full),
    .empty  (bus.empty),
    .level  (bus.level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE:  if (!bus.empty)       state_d = TX_START;
      TX_START:                       state_d = TX_WAIT;
      TX_WAIT:  if (bus.tx_done_tick) state_d = TX_IDLE;
      default:                        state_d = TX_IDLE;
    endcase
  end

  // Outputs depend on the state register alone so the transmitter never sees a combinational glitch.
  always_comb begin
    tx_start = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      TX_START: begin
        tx_start = 1'b1;
        busy     = 1'b1;
      end
      TX_WAIT:  busy = 1'b1;
      default:  ;
    endcase
  end

  assign bus.tx_start = tx_start;
  assign bus.busy     = busy;

`ifdef UART_TXQ_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr)           ovf_d = 1'b0;
    if (bus.wr && bus.full)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = bus.ovf_clr;
  assign bus.ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

  localparam int DBIT   = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

`ifdef UART_TXQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DBIT(DBIT), .ADDR_W(ADDR_W)) bus ();

  uart_tx_feeder #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        wr;
    logic [7:0] data;
    bit        done;
    int        lvl;
    bit        st;
    bit        bsy;
    logic [7:0] din;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(bit w, logic [7:0] d, bit dn, int l, bit s, bit b, logic [7:0] din);
    vec_t v;
    v.wr = w; v.data = d; v.done = dn; v.lvl = l; v.st = s; v.bsy = b; v.din = din;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int l, input bit s, input bit b);
    chk({tag, "_level"}, int'(bus.level), l);
    chk({tag, "_empty"}, int'(bus.empty), int'(l == 0));
    chk({tag, "_full"},  int'(bus.full),  int'(l == DEPTH));
    chk({tag, "_start"}, int'(bus.tx_start), int'(s));
    chk({tag, "_busy"},  int'(bus.busy), int'(b));
  endtask

  // Inputs change just after a falling edge and outputs are inspected at the next falling edge.
  task automatic drive(input bit w, input logic [7:0] d, input bit dn, input bit clr);
    bus.wr           = w;
    bus.w_data       = d;
    bus.tx_done_tick = dn;
    bus.ovf_clr      = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  logic [7:0] mq [$];
  bit   m_start, m_wait, m_ovf;
  int   tx_cnt;
  int   wr_pct;

  initial begin
    int last_start, last_done, nstart;

    reset = 1'b1;
    bus.wr = 1'b0; bus.w_data = '0; bus.tx_done_tick = 1'b0; bus.ovf_clr = 1'b0;

    vecs[0]  = mk(1, 8'hA5, 0, 1, 0, 0, 8'h00);
    vecs[1]  = mk(0, 8'h00, 0, 1, 1, 1, 8'hA5);
    vecs[2]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h00);
    vecs[3]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h00);
    vecs[4]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00);
    vecs[5]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h00);
    vecs[6]  = mk(0, 8'h00, 0, 0, 0, 0, 8'h00);
    vecs[7]  = mk(1, 8'h01, 0, 1, 0, 0, 8'h00);
    vecs[8]  = mk(1, 8'h02, 0, 2, 1, 1, 8'h01);
    vecs[9]  = mk(1, 8'h03, 0, 2, 0, 1, 8'h00);
    vecs[10] = mk(0, 8'h00, 0, 2, 0, 1, 8'h00);

    do_reset();
    check_outs("reset", 0, 1'b0, 1'b0);
    chk("reset_ovf", int'(bus.ovf), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].data, vecs[i].done, 1'b0);
      check_outs($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].st, vecs[i].bsy);
      if (vecs[i].st) chk($sformatf("vec%0d_din", i), int'(bus.tx_din), int'(vecs[i].din));
    end

    // Transmitter answers 160 cycles after each start; 0x01 started two cycles before this loop.
    last_start = -2; last_done = -1000; nstart = 0;
    for (int k = 0; k < 600; k++) begin
      bit dn;
      if (bus.tx_start) begin
        if (nstart < 2) begin
          chk("seq_data", int'(bus.tx_din), 2 + nstart);
          chk("seq_gap", k - last_done, 2);
        end
        nstart++;
        last_start = k;
      end
      dn = (k - last_start == 160);
      if (dn) last_done = k;
      drive(1'b0, 8'h00, dn, 1'b0);
    end
    chk("seq_count", nstart, 2);
    check_outs("seq_end", 0, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 17; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    check_outs("fill", DEPTH, 1'b0, 1'b1);
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    check_outs("drop", DEPTH, 1'b0, 1'b1);
    chk("drop_ovf", int'(bus.ovf), int'(OVF_EN));
    drive(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("ovf_set_wins", int'(bus.ovf), int'(OVF_EN));
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", int'(bus.ovf), 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_outs("full_idle", DEPTH, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check_outs("full_start", DEPTH, 1'b1, 1'b1);
    chk("full_start_din", int'(bus.tx_din), 8'h11);
    drive(1'b1, 8'hCC, 1'b0, 1'b0);
    check_outs("pop_drop", DEPTH - 1, 1'b0, 1'b1);
    chk("pop_drop_ovf", int'(bus.ovf), int'(OVF_EN));

    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    check_outs("wait5", 5, 1'b0, 1'b1);
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    check_outs("rst_wait", 0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_outs($sformatf("stray%0d", i), 0, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Random traffic against a frame-level reference: a byte queue plus whether a frame is loading or on the line.
    do_reset();
    mq.delete(); m_start = 0; m_wait = 0; m_ovf = 0; tx_cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      bit w, dn, clr, rst, was_full, was_empty;
      logic [7:0] d;
      check_outs("rnd", mq.size(), m_start, m_start | m_wait);
      chk("rnd_ovf", int'(bus.ovf), int'(m_ovf));
      if (m_start) chk("rnd_din", int'(bus.tx_din), int'(mq[0]));

      wr_pct = ((k / 500) % 2 == 0) ? 80 : 30;
      w   = ($urandom_range(99) < wr_pct);
      d   = 8'($urandom);
      clr = ($urandom_range(15) == 0);
      rst = ($urandom_range(399) == 0);
      dn  = ($urandom_range(63) == 0);
      if (bus.tx_start) tx_cnt = $urandom_range(12, 1);
      else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) dn = 1'b1;
      end

      if (rst) begin
        mq.delete(); m_start = 0; m_wait = 0; m_ovf = 0; tx_cnt = 0;
      end else begin
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (clr) m_ovf = 1'b0;
        if (w && was_full && OVF_EN) m_ovf = 1'b1;
        if (m_start) begin
          void'(mq.pop_front());
          m_start = 1'b0;
          m_wait  = 1'b1;
        end else if (m_wait) begin
          if (dn) m_wait = 1'b0;
        end else if (!was_empty) begin
          m_start = 1'b1;
        end
        if (w && !was_full) mq.push_back(d);
      end

      reset = rst;
      drive(w, d, dn, clr);
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
